// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant among ALU/LSU/MDU results, one registered
// register-file write per cycle, and a per-register pending scoreboard for issue.
module wb_arbiter #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_d,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_d,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [RW-1:0]   mdu_rd,
  input  logic [XLEN-1:0] mdu_d,
  input  logic            iss_en,
  input  logic [RW-1:0]   iss_rd,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            iss_rd_busy,
  output logic [XLEN-1:0] wb_d,
  output logic [RW-1:0]   wb_rd,
  output logic            wb_wr
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;

  src_e            r_p;
  src_e            w_sel;
  src_e            w_p_next;
  logic            w_any;
  logic [XLEN-1:0] w_d;
  logic [RW-1:0]   w_rd;

  logic [NREG-1:0] r_pending;
  logic [XLEN-1:0] r_wb_d;
  logic [RW-1:0]   r_wb_rd;
  logic            r_wb_wr;

  // Scan from the pointer upward, wrapping; the first valid source wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_any = 1'b1;
    w_sel = SRC_ALU;
    case (r_p)
      SRC_LSU: begin
        if      (lsu_valid) w_sel = SRC_LSU;
        else if (mdu_valid) w_sel = SRC_MDU;
        else if (alu_valid) w_sel = SRC_ALU;
        else                w_any = 1'b0;
      end
      SRC_MDU: begin
        if      (mdu_valid) w_sel = SRC_MDU;
        else if (alu_valid) w_sel = SRC_ALU;
        else if (lsu_valid) w_sel = SRC_LSU;
        else                w_any = 1'b0;
      end
      default: begin
        if      (alu_valid) w_sel = SRC_ALU;
        else if (lsu_valid) w_sel = SRC_LSU;
        else if (mdu_valid) w_sel = SRC_MDU;
        else                w_any = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_d  = alu_d;
    w_rd = alu_rd;
    case (w_sel)
      SRC_LSU: begin
        w_d  = lsu_d;
        w_rd = lsu_rd;
      end
      SRC_MDU: begin
        w_d  = mdu_d;
        w_rd = mdu_rd;
      end
      default: ;
    endcase
  end

  assign w_p_next = (w_sel == SRC_MDU) ? SRC_ALU : src_e'(w_sel + 2'd1);

  assign alu_ready = rst_n && w_any && (w_sel == SRC_ALU);
  assign lsu_ready = rst_n && w_any && (w_sel == SRC_LSU);
  assign mdu_ready = rst_n && w_any && (w_sel == SRC_MDU);

  // Lookups see only registered state; the write happening this cycle is not bypassed.
  assign rs1_busy    = r_pending[rs1];
  assign rs2_busy    = r_pending[rs2];
  assign iss_rd_busy = r_pending[iss_rd];

  assign wb_d  = r_wb_d;
  assign wb_rd = r_wb_rd;
  assign wb_wr = r_wb_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      r_p     <= SRC_ALU;
      r_wb_wr <= 1'b0;
      r_wb_rd <= '0;
      r_wb_d  <= '0;
      // NOTE: the pending array is control state, so unlike a data RAM it must be reset.
      r_pending <= '0;
    end else begin
      r_wb_wr <= w_any && (w_rd != '0);
      if (w_any) begin
        r_wb_d  <= w_d;
        r_wb_rd <= w_rd;
        r_p     <= w_p_next;
      end
      // Entry 0 is never written, so x0 never reads busy. A new issue beats a same-edge clear.
      for (int i = 1; i < NREG; i++) begin
        if (iss_en && (iss_rd == RW'(i)))
          r_pending[i] <= 1'b1;
        else if (r_wb_wr && (r_wb_rd == RW'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table of round-robin vectors with a writeback
// scoreboard, followed by hand-written scoreboard-hazard and reset sequences.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [63:0] alu_d, lsu_d, mdu_d;
  logic        iss_en;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy, iss_rd_busy;
  logic [63:0] wb_d;
  logic [4:0]  wb_rd;
  logic        wb_wr;

  wb_arbiter #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_d(alu_d),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_d(lsu_d),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_d(mdu_d),
    .iss_en(iss_en), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .iss_rd_busy(iss_rd_busy),
    .wb_d(wb_d), .wb_rd(wb_rd), .wb_wr(wb_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] valid;      // {mdu, lsu, alu}
    logic [4:0] rd_a;
    logic [4:0] rd_l;
    logic [4:0] rd_m;
    logic [2:0] exp_ready;  // {mdu, lsu, alu}
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [63:0] d;
  } wb_t;

  vec_t        vecs[10];
  wb_t         sb_q[$];
  logic [4:0]  last_rd;
  logic [63:0] last_d;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    wb_t e;
    sb_q.delete();
    e.wr = 1'b0; e.rd = '0; e.d = '0;
    last_rd = '0;
    last_d  = '0;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string name);
    wb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got wb_wr=%0b", name, wb_wr);
    end else begin
      e = sb_q.pop_front();
      check({name, " wb_wr"}, {63'b0, wb_wr}, {63'b0, e.wr});
      check({name, " wb_rd"}, {59'b0, wb_rd}, {59'b0, e.rd});
      check({name, " wb_d"}, wb_d, e.d);
    end
  endtask

  // Drive one cycle of source traffic, check readies and last cycle's writeback,
  // then queue the writeback implied by the expected grant.
  task automatic apply(input string name, input logic [2:0] v,
                       input logic [4:0] ra, input logic [4:0] rl, input logic [4:0] rm,
                       input logic [63:0] da, input logic [63:0] dl, input logic [63:0] dm,
                       input logic [2:0] exp_rdy);
    wb_t e;
    alu_valid = v[0]; alu_rd = ra; alu_d = da;
    lsu_valid = v[1]; lsu_rd = rl; lsu_d = dl;
    mdu_valid = v[2]; mdu_rd = rm; mdu_d = dm;
    #4;
    check({name, " ready"}, {61'b0, mdu_ready, lsu_ready, alu_ready}, {61'b0, exp_rdy});
    sb_check(name);
    e.wr = 1'b0; e.rd = last_rd; e.d = last_d;
    if      (exp_rdy[0]) begin e.rd = ra; e.d = da; end
    else if (exp_rdy[1]) begin e.rd = rl; e.d = dl; end
    else if (exp_rdy[2]) begin e.rd = rm; e.d = dm; end
    if (exp_rdy != 3'b000) e.wr = (e.rd != 5'd0);
    last_rd = e.rd;
    last_d  = e.d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
  endtask

  task automatic idle(input string name);
    apply(name, 3'b000, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 3'b000);
  endtask

  function automatic logic [63:0] d_of(input int row, input int src);
    return 64'hA5A5_0000_0000_0000 | 64'(row << 8) | 64'(src);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    // Rows run back-to-back from p=0 after reset; expected grants derived by hand.
    vecs[0] = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b001};
    vecs[1] = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b010};
    vecs[2] = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b100};
    vecs[3] = '{3'b111, 5'd1,  5'd2,  5'd3,  3'b001};
    vecs[4] = '{3'b101, 5'd10, 5'd11, 5'd12, 3'b100};
    vecs[5] = '{3'b110, 5'd13, 5'd14, 5'd15, 3'b010};
    vecs[6] = '{3'b000, 5'd0,  5'd0,  5'd0,  3'b000};
    vecs[7] = '{3'b011, 5'd16, 5'd17, 5'd18, 3'b001};
    vecs[8] = '{3'b001, 5'd0,  5'd20, 5'd21, 3'b001};
    vecs[9] = '{3'b010, 5'd22, 5'd23, 5'd24, 3'b010};

    rst_n = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b1; mdu_valid = 1'b1;
    alu_rd = '0; lsu_rd = '0; mdu_rd = '0;
    alu_d = '0; lsu_d = '0; mdu_d = '0;
    iss_en = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset readies", {61'b0, mdu_ready, lsu_ready, alu_ready}, 64'd0);
    check("reset rs1_busy", {63'b0, rs1_busy}, 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    rst_n = 1'b1;
    sb_reset();

    // Round-robin table, including the all-valid rotation and an rd=0 grant.
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rd_a, vecs[i].rd_l, vecs[i].rd_m,
            d_of(i, 0), d_of(i, 1), d_of(i, 2), vecs[i].exp_ready);
    end

    // Single ALU result: one-cycle latency, then wb_wr drops while rd/d hold.
    apply("t1_alu", 3'b001, 5'd5, 5'd0, 5'd0, 64'h1234, 64'd0, 64'd0, 3'b001);
    idle("t1_wb");
    idle("t1_hold");

    // Pending bit set by issue, held through the writeback cycle, cleared after.
    rs1 = 5'd7; rs2 = 5'd7; #1;
    check("t3 rs1_busy before issue", {63'b0, rs1_busy}, 64'd0);
    iss_en = 1'b1; iss_rd = 5'd7;
    idle("t3_issue");
    iss_en = 1'b0; #1;
    check("t3 rs1_busy after issue", {63'b0, rs1_busy}, 64'd1);
    check("t3 rs2_busy after issue", {63'b0, rs2_busy}, 64'd1);
    apply("t3_lsu", 3'b010, 5'd0, 5'd7, 5'd0, 64'd0, 64'h77, 64'd0, 3'b010);
    check("t3 rs1_busy in wb cycle", {63'b0, rs1_busy}, 64'd1);
    idle("t3_wb");
    check("t3 rs1_busy after wb", {63'b0, rs1_busy}, 64'd0);

    // Same-edge issue and writeback of one register: the new issue keeps it pending.
    iss_en = 1'b1; iss_rd = 5'd9;
    idle("t4_issue");
    iss_en = 1'b0;
    apply("t4_mdu", 3'b100, 5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 64'h99, 3'b100);
    iss_en = 1'b1; iss_rd = 5'd9; #1;
    check("t4 iss_rd_busy in wb cycle", {63'b0, iss_rd_busy}, 64'd1);
    idle("t4_wb");
    iss_en = 1'b0; rs2 = 5'd9; #1;
    check("t4 iss_rd_busy after collision", {63'b0, iss_rd_busy}, 64'd1);
    check("t4 rs2_busy after collision", {63'b0, rs2_busy}, 64'd1);

    // rd=0 result: accepted, no register write, x0 never busy even when issued.
    rs1 = 5'd0; iss_en = 1'b1; iss_rd = 5'd0; #1;
    check("t5 rs1_busy x0 before", {63'b0, rs1_busy}, 64'd0);
    apply("t5_mdu", 3'b100, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'hFFFF, 3'b100);
    iss_en = 1'b0; #1;
    check("t5 rs1_busy x0 after issue", {63'b0, rs1_busy}, 64'd0);
    idle("t5_wb");
    check("t5 rs1_busy x0 after wb", {63'b0, rs1_busy}, 64'd0);

    // Reset in the writeback cycle drops the write and the pending bit.
    iss_en = 1'b1; iss_rd = 5'd4;
    idle("t6_issue");
    iss_en = 1'b0; rs1 = 5'd4; #1;
    check("t6 rs1_busy after issue", {63'b0, rs1_busy}, 64'd1);
    apply("t6_alu", 3'b001, 5'd4, 5'd0, 5'd0, 64'h44, 64'd0, 64'd0, 3'b001);
    sb_check("t6_wb_before_reset");
    rst_n = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b1; mdu_valid = 1'b1;
    alu_rd = 5'd1; lsu_rd = 5'd2; mdu_rd = 5'd3;
    alu_d = 64'h11; lsu_d = 64'h22; mdu_d = 64'h33;
    #1;
    check("t6 readies in reset", {61'b0, mdu_ready, lsu_ready, alu_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("t6 wb_wr after reset edge", {63'b0, wb_wr}, 64'd0);
    check("t6 wb_rd after reset edge", {59'b0, wb_rd}, 64'd0);
    check("t6 wb_d after reset edge", wb_d, 64'd0);
    check("t6 rs1_busy after reset edge", {63'b0, rs1_busy}, 64'd0);
    check("t6 readies held in reset", {61'b0, mdu_ready, lsu_ready, alu_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_reset();
    apply("t6_post", 3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 3'b001);
    apply("t6_post2", 3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33, 3'b010);
    idle("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
